// File: rtl/pipe_alu_mdu.sv
// pipe_alu_mdu: registered EX-stage ALU with an iterative unsigned multiplier writing HI/LO
module pipe_alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             OutValid,
    output logic [WIDTH-1:0] DataOut,
    output logic             Zero,
    output logic             Overflow
);
    localparam logic [5:0] F_AND = 6'b100100, F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111;
    localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010, F_SUBU = 6'b100011;
    localparam logic [5:0] F_SLT = 6'b101010, F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MULTU = 6'b011001;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo, mcand, res, addend, sum, diff;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH:0]     psum;
    logic [SHW-1:0]     cnt, sh;
    logic               ovf;

    assign InReady = !Reset && state == IDLE;
    assign sh      = DataB[SHW-1:0];
    assign sum     = DataA + DataB;
    assign diff    = DataA - DataB;
    assign addend  = acc[0] ? mcand : '0;
    assign psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign acc_nx  = {psum, acc[WIDTH-1:1]};

    // single-cycle result and signed-overflow flag for the presented funct
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (Signal)
            F_AND:  res = DataA & DataB;
            F_OR:   res = DataA | DataB;
            F_XOR:  res = DataA ^ DataB;
            F_NOR:  res = ~(DataA | DataB);
            F_ADD: begin
                res = sum;
                ovf = (DataA[WIDTH-1] == DataB[WIDTH-1]) && (sum[WIDTH-1] != DataA[WIDTH-1]);
            end
            F_ADDU: res = sum;
            F_SUB: begin
                res = diff;
                ovf = (DataA[WIDTH-1] != DataB[WIDTH-1]) && (diff[WIDTH-1] != DataA[WIDTH-1]);
            end
            F_SUBU: res = diff;
            F_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(DataA) < $signed(DataB)};
            F_SLTU: res = {{(WIDTH-1){1'b0}}, DataA < DataB};
            F_SLL:  res = DataA << sh;
            F_SRL:  res = DataA >> sh;
            F_SRA:  res = $signed(DataA) >>> sh;
            F_MFHI: res = hi;
            F_MFLO: res = lo;
            default: res = '0;
        endcase
    end

    // issue control, multiply iteration and registered outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            OutValid <= 1'b0;
            DataOut  <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            mcand    <= '0;
            cnt      <= '0;
        end else begin
            OutValid <= 1'b0;
            case (state)
                IDLE: if (InValid) begin
                    if (Signal == F_MULTU) begin
                        state <= MUL;
                        mcand <= DataA;
                        acc   <= {{WIDTH{1'b0}}, DataB};
                        cnt   <= '0;
                    end else begin
                        DataOut  <= res;
                        Zero     <= res == '0;
                        Overflow <= ovf;
                        OutValid <= 1'b1;
                    end
                end
                MUL: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        hi       <= acc_nx[2*WIDTH-1:WIDTH];
                        lo       <= acc_nx[WIDTH-1:0];
                        DataOut  <= acc_nx[WIDTH-1:0];
                        Zero     <= acc_nx[WIDTH-1:0] == '0;
                        Overflow <= 1'b0;
                        OutValid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pipe_alu_mdu.md
Name: pipe_alu_mdu

Overview:
- Registered, parametrised successor to the single-cycle 32-bit ripple ALU in the EX stage of the pipelined MIPS core.
- Adds XOR, NOR, unsigned add/sub/compare, SLL and SRA shifts, signed-overflow and zero flags.
- Adds an iterative unsigned multiplier (MULTU) writing internal HI/LO registers, read back with MFHI/MFLO.
- Uses a valid/ready input handshake so the hazard unit can stall issue while a multiply is in flight.

Parameters:
- WIDTH, 32, datapath width in bits (even, at least 8).
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operation presented this cycle.
- InReady  output  1  block can accept an operation this cycle.
- Signal  input  6  funct code selecting the operation.
- DataA  input  WIDTH  operand A; also the shifted operand for SLL/SRL/SRA.
- DataB  input  WIDTH  operand B; DataB[SHW-1:0] is the shift amount for shifts.
- OutValid  output  1  one-cycle pulse: DataOut and the flags are valid.
- DataOut  output  WIDTH  result.
- Zero  output  1  DataOut == 0, registered with DataOut.
- Overflow  output  1  signed overflow on ADD/SUB.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: when Reset is high at a rising edge, these are all cleared to 0 and the FSM goes to IDLE: OutValid, DataOut, Zero, Overflow, HI, LO, the iteration counter and the multiply accumulator.
- InReady = !Reset && state==IDLE. An operation is accepted when InValid && InReady at a rising edge.
- Funct codes:
  - AND 100100, OR 100101, XOR 100110, NOR 100111
  - ADD 100000, ADDU 100001, SUB 100010, SUBU 100011
  - SLT 101010, SLTU 101011
  - SLL 000000, SRL 000010, SRA 000011
  - MFHI 010000, MFLO 010010, MULTU 011001
- Single-cycle ops (all except MULTU):
  - Result is registered on the accepting edge; OutValid is high the next cycle only.
  - Latency is 1. Back-to-back issue is allowed every cycle.
- Arithmetic rules:
  - Add/sub wrap modulo 2^WIDTH.
  - Overflow=1 only for ADD/SUB when the operand signs make signed overflow (ADD: both operands same sign, result differs; SUB: operands differ in sign, result sign differs from A). It is 0 for every other op.
  - SLT is a signed compare, SLTU unsigned; each gives 1 or 0 zero-extended to WIDTH.
- Shifts:
  - Amount is DataB[SHW-1:0]; upper DataB bits are ignored.
  - SRA fills with DataA[WIDTH-1]; SLL and SRL fill with 0.
- MFHI/MFLO return the current HI/LO.
- Unknown funct: DataOut=0, Zero=1, Overflow=0, OutValid still pulses.
- Multiply FSM (IDLE, MUL):
  - On MULTU acceptance: go to MUL; load the multiplicand from DataA, the multiplier from DataB into the low half of a 2*WIDTH accumulator, upper half 0; counter=0.
  - Each MUL cycle: if accumulator LSB is 1, add the multiplicand to the upper half (WIDTH+1-bit sum); then shift the accumulator right by 1; counter++.
  - After WIDTH iterations: HI/LO take the accumulator halves, OutValid pulses with DataOut=LO (Zero from LO, Overflow=0), FSM returns to IDLE.
  - Acceptance at edge E gives OutValid high in cycle E+WIDTH. InReady is low for WIDTH cycles and high again in the OutValid cycle, so the next op may issue then.
- While in MUL, InValid is ignored; operands are not captured or queued.
- HI/LO change only on MULTU completion or Reset.
- Reset during MUL aborts the multiply: no OutValid, HI/LO=0, InReady high in the first cycle after Reset falls.
- OutValid has no backpressure. Outputs hold their last value when OutValid is low, except after Reset.

Test Plan:
- ADD 0x7FFFFFFF,0x00000001 -> next cycle OutValid=1, DataOut=0x80000000, Overflow=1. Same operands with ADDU -> Overflow=0.
- SUB 5,5 -> DataOut 0, Zero=1. SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0. Issue these three back-to-back -> three consecutive OutValid pulses.
- SRA 0x80000000 with DataB=0x24 -> 0xF8000000. SRL same -> 0x08000000. SLL 0x00000001 with DataB=31 -> 0x80000000.
- MULTU 0xFFFFFFFF,0xFFFFFFFF:
  - InReady low for 32 cycles; an InValid ADD during that window is ignored.
  - OutValid arrives 32 cycles after acceptance with DataOut=0x00000001.
  - Then MFHI -> 0xFFFFFFFE and MFLO -> 0x00000001.
- MULTU 3,4, then Reset for one cycle at iteration 10 -> no OutValid; the following MFHI and MFLO both return 0; InReady high the cycle after Reset falls.
- WIDTH=16, SHW=4: MULTU 0xFFFF,0x0002 -> OutValid 16 cycles after acceptance with LO=0xFFFE; MFHI -> 0x0001. SRA 0x8000 by 3 -> 0xF000.
